// File: rtl/alureg_seq.sv
// alureg_seq: three-state sequenced ALU with a small register file, 8080-style flag word and debug read port
module alureg_seq #(
    parameter int DATASIZE = 8,
    parameter int REGADDR  = 3,
    parameter int FLAG_S   = 7,
    parameter int FLAG_Z   = 6,
    parameter int FLAG_A   = 4,
    parameter int FLAG_P   = 2,
    parameter int FLAG_C   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [3:0]          op_code,
    input  logic [REGADDR-1:0]  op_dst,
    input  logic [REGADDR-1:0]  op_src,
    input  logic [DATASIZE-1:0] op_imm,
    input  logic                op_useimm,
    output logic                res_valid,
    output logic [DATASIZE-1:0] res_data,
    output logic [7:0]          res_flags,
    input  logic [REGADDR-1:0]  dbg_addr,
    output logic [DATASIZE-1:0] dbg_data
);
    localparam int NREG = 2 ** REGADDR;
    localparam int W1   = DATASIZE + 1;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t              state, state_nxt;
    logic [DATASIZE-1:0] regs [NREG];
    logic [3:0]          l_code;
    logic [REGADDR-1:0]  l_dst, l_src;
    logic [DATASIZE-1:0] l_imm;
    logic                l_useimm;
    logic                f_s, f_z, f_a, f_p, f_c;
    logic [DATASIZE-1:0] h_data;
    logic                h_wr, h_s, h_z, h_a, h_p, h_c;
    logic                accept, is_sub, is_arith, k, upd, wr;
    logic                n_s, n_z, n_a, n_p, n_c;
    logic [DATASIZE-1:0] a, b, y, r;
    logic [DATASIZE:0]   wide;
    logic [4:0]          nib;

    assign dbg_data = regs[dbg_addr];

    // handshake, next state and result strobe; only EXEC refuses a new operation
    always_comb begin
        op_ready  = (state != EXEC);
        accept    = op_valid && op_ready;
        state_nxt = (state == EXEC) ? WB : (accept ? EXEC : IDLE);
        res_valid = (state == WB);
        res_data  = res_valid ? h_data : '0;
    end

    // ALU on the latched operation; INR/DCR reuse the adder with a constant 1 operand
    always_comb begin
        a        = regs[l_dst];
        b        = l_useimm ? l_imm : regs[l_src];
        is_sub   = l_code inside {4'd2, 4'd3, 4'd7, 4'd9};
        is_arith = l_code inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9};
        y        = (l_code inside {4'd8, 4'd9}) ? DATASIZE'(1) : b;
        k        = (l_code inside {4'd1, 4'd3}) && f_c;
        wide     = is_sub ? {1'b0, a} - {1'b0, y} - W1'(k) : {1'b0, a} + {1'b0, y} + W1'(k);
        nib      = is_sub ? {1'b0, a[3:0]} - {1'b0, y[3:0]} - 5'(k) : {1'b0, a[3:0]} + {1'b0, y[3:0]} + 5'(k);
        r        = is_arith ? wide[DATASIZE-1:0] :
                   (l_code == 4'd4) ? (a & b) :
                   (l_code == 4'd5) ? (a ^ b) :
                   (l_code == 4'd6) ? (a | b) :
                   (l_code == 4'd10) ? b : a;
        upd      = (l_code <= 4'd9);
        wr       = (l_code <= 4'd10) && (l_code != 4'd7);
        n_s      = upd ? r[DATASIZE-1] : f_s;
        n_z      = upd ? (r == '0) : f_z;
        n_p      = upd ? ~^r : f_p;
        n_a      = !upd ? f_a : (is_arith ? nib[4] : (l_code == 4'd4));
        n_c      = (l_code <= 4'd7) ? (is_arith && wide[DATASIZE]) : f_c;
    end

    // flag word assembly with the fixed bits forced last so they win over any flag placement
    always_comb begin
        res_flags         = 8'h00;
        res_flags[FLAG_S] = f_s;
        res_flags[FLAG_Z] = f_z;
        res_flags[FLAG_A] = f_a;
        res_flags[FLAG_P] = f_p;
        res_flags[FLAG_C] = f_c;
        res_flags[1]      = 1'b1;
        res_flags[3]      = 1'b0;
        res_flags[5]      = 1'b0;
    end

    // state, operation latch, EXEC holding registers and WB commit of register and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            l_code   <= '0;
            l_dst    <= '0;
            l_src    <= '0;
            l_imm    <= '0;
            l_useimm <= 1'b0;
            h_data   <= '0;
            {h_wr, h_s, h_z, h_a, h_p, h_c} <= '0;
            {f_s, f_z, f_a, f_p, f_c} <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                l_code   <= op_code;
                l_dst    <= op_dst;
                l_src    <= op_src;
                l_imm    <= op_imm;
                l_useimm <= op_useimm;
            end
            if (state == EXEC) begin
                h_data <= r;
                {h_wr, h_s, h_z, h_a, h_p, h_c} <= {wr, n_s, n_z, n_a, n_p, n_c};
            end
            if (state == WB) begin
                if (h_wr) regs[l_dst] <= h_data;
                {f_s, f_z, f_a, f_p, f_c} <= {h_s, h_z, h_a, h_p, h_c};
            end
        end
    end
endmodule
